// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel coordinate, sync and colour bundle between timing generator and sprite/DAC side
interface vga_timing_gen_if;
  logic [5:0] rgb_in;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [5:0] rgb_out;

  // timing generator side
  modport master (
    input  rgb_in,
    output hcount, vcount, active, frame_start, hsync, vsync, rgb_out
  );

  // sprite path / DAC side
  modport slave (
    output rgb_in,
    input  hcount, vcount, active, frame_start, hsync, vsync, rgb_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA counters, sync generation and 2-cycle colour pipeline; VGA_TEST_PATTERN_EN selects colour bars
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input logic             clk,
  input logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;

  // stage 1: tags of the coordinate issued last cycle
  logic       s1_active;
  logic       s1_hs;
  logic       s1_vs;

  // stage 2: outputs to the DAC
  logic       hsync_q;
  logic       vsync_q;
  logic [5:0] rgb_q;

  // Raster counters: vcount steps only on the hcount wrap cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  assign active = (hcount < H_VIS) && (vcount < V_VIS);
  assign hs_raw = !((hcount >= H_SYNC_LO) && (hcount < H_SYNC_HI));
  assign vs_raw = !((vcount >= V_SYNC_LO) && (vcount < V_SYNC_HI));

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  logic [2:0] s1_bar;
  logic       unused_rgb_in;

  // Bars are 80 px wide, so the bar index is the quotient of the visible column
  assign bar           = 3'(hcount / 10'd80);
  assign unused_rgb_in = ^vga.rgb_in;

  // Stage 1 also carries the bar index so colour stays aligned with sync
  always_ff @(posedge clk) begin
    if (rst) s1_bar <= '0;
    else     s1_bar <= bar;
  end
`endif

  // Stage 1 tagging of coordinate t; rgb_in for t arrives during the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_active <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
    end else begin
      s1_active <= active;
      s1_hs     <= hs_raw;
      s1_vs     <= vs_raw;
    end
  end

  // Stage 2 output register: colour blanked outside the visible area
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      hsync_q <= s1_hs;
      vsync_q <= s1_vs;
`ifdef VGA_TEST_PATTERN_EN
      rgb_q   <= s1_active ? {s1_bar[2], s1_bar[2], s1_bar[1], s1_bar[1], s1_bar[0], s1_bar[0]} : 6'd0;
`else
      rgb_q   <= s1_active ? vga.rgb_in : 6'd0;
`endif
    end
  end

  assign vga.hcount      = hcount;
  assign vga.vcount      = vcount;
  assign vga.active      = active;
  assign vga.frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a cycle-index raster model
module tb_vga_timing_gen;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 20,  VF = 3,  VS = 2,  VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [5:0] CONST_RGB = 6'h3F;
`else
  localparam logic [5:0] CONST_RGB = 6'h2A;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vif();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif)
  );

  int total = 0;
  int bad   = 0;

  // model state: n = cycles since the last reset edge, age = pipeline fill (0..2)
  int         n = 0;
  int         age = 0;
  int         cyc = 0;
  int         mode = 0;
  logic [5:0] cur_rgb = '0;
  logic [5:0] last_rgb = '0;
  int         hs_run = 0, vs_run = 0;
  logic       hs_prev = 1'b1, vs_prev = 1'b1;
  int         last_fs = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs from raster position arithmetic on the cycle index
  task automatic check_cycle();
    int h = n % HT;
    int v = (n / HT) % VT;
    logic       e_hs  = 1'b1;
    logic       e_vs  = 1'b1;
    logic [5:0] e_rgb = 6'd0;
    chk("hcount", vif.hcount, h);
    chk("vcount", vif.vcount, v);
    chk("active", vif.active, (h < HV && v < VV) ? 1 : 0);
    chk("frame_start", vif.frame_start, (h == 0 && v == 0) ? 1 : 0);
    if (age >= 2) begin
      int t  = n - 2;
      int th = t % HT;
      int tv = (t / HT) % VT;
      logic [2:0] b;
      e_hs = !(th >= HV + HF && th < HV + HF + HS);
      e_vs = !(tv >= VV + VF && tv < VV + VF + VS);
      if (th < HV && tv < VV) begin
        b = 3'(th / 80);
`ifdef VGA_TEST_PATTERN_EN
        e_rgb = {b[2], b[2], b[1], b[1], b[0], b[0]};
`else
        e_rgb = last_rgb;
`endif
      end
    end
    chk("hsync", vif.hsync, e_hs);
    chk("vsync", vif.vsync, e_vs);
    chk("rgb_out", vif.rgb_out, e_rgb);
  endtask

  // One clock: drive inputs mid-cycle, advance the model at the edge, check at the falling edge
  task automatic tick(input logic r);
    rst = r;
    cur_rgb = (mode == 0) ? 6'($urandom) : CONST_RGB;
    vif.rgb_in = cur_rgb;
    @(posedge clk);
    if (r) begin
      n = 0;
      age = 0;
    end else begin
      n++;
      if (age < 2) age++;
    end
    last_rgb = cur_rgb;
    @(negedge clk);
    cyc++;
    check_cycle();
    if (r) begin
      hs_run = 0; vs_run = 0; hs_prev = 1'b1; vs_prev = 1'b1;
      last_fs = cyc;
    end else begin
      if (vif.hsync === 1'b0) begin
        if (hs_prev) chk("hsync_start_hcount", vif.hcount, HV + HF + 2);
        hs_run++;
      end else if (!hs_prev) begin
        chk("hsync_width", hs_run, HS);
        hs_run = 0;
      end
      if (vif.vsync === 1'b0) begin
        if (vs_prev) begin
          chk("vsync_start_hcount", vif.hcount, 2);
          chk("vsync_start_vcount", vif.vcount, VV + VF);
        end
        vs_run++;
      end else if (!vs_prev) begin
        chk("vsync_width", vs_run, VS * HT);
        vs_run = 0;
      end
      hs_prev = vif.hsync;
      vs_prev = vif.vsync;
      if (vif.frame_start === 1'b1) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME);
        last_fs = cyc;
      end
    end
  endtask

  initial begin
    vif.rgb_in = '0;

    // reset held for three cycles, then released
    mode = 0;
    repeat (3) tick(1'b1);
    chk("rst_hsync", vif.hsync, 1);
    chk("rst_vsync", vif.vsync, 1);
    chk("rst_rgb_out", vif.rgb_out, 0);
    chk("rel_frame_start", vif.frame_start, 1);
    chk("rel_active", vif.active, 1);

    // one full frame of random colour input
    repeat (FRAME + 10) tick(1'b0);

    // advance to hcount=700, vcount=10 and pulse reset for a single cycle
    for (int i = 0; i < 2 * FRAME && !((n % HT) == 700 && ((n / HT) % VT) == 10); i++)
      tick(1'b0);
    chk("pre_rst_hcount", vif.hcount, 700);
    chk("pre_rst_hsync", vif.hsync, 0);
    tick(1'b1);
    chk("midrst_hcount", vif.hcount, 0);
    chk("midrst_vcount", vif.vcount, 0);
    chk("midrst_hsync", vif.hsync, 1);
    chk("midrst_rgb_out", vif.rgb_out, 0);

    // constant colour input across a full frame
    mode = 1;
    tick(1'b0);
    tick(1'b0);
    chk("first_pixel_rgb", vif.rgb_out,
`ifdef VGA_TEST_PATTERN_EN
        6'h00
`else
        CONST_RGB
`endif
    );
    repeat (FRAME + 10) tick(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
